// File: rtl/bluster_pkg.sv
// rtl/bluster_pkg.sv - shared state type, bus level constants and helpers for the Zorro DMA master
package bluster_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAITFREE,
    ADDR,
    STRB,
    WAIT,
    TERM,
    REL
  } zdm_state_t;

  // Zorro control lines are active low
  localparam logic ASSERTED_L = 1'b0;
  localparam logic NEGATED_L  = 1'b1;

  // No byte lane selected is meaningless on the bus; it becomes a full word access
  function automatic logic [1:0] fix_ben(input logic [1:0] b);
    return (b == 2'b00) ? 2'b11 : b;
  endfunction

endpackage

// File: rtl/bluster_sync.sv
// rtl/bluster_sync.sv - multi-flop synchronizer for one asynchronous active-low bus input
module bluster_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Resets to the negated level so no bus line appears asserted out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/zorro_dma_master.sv
// rtl/zorro_dma_master.sv - Zorro II bus-master engine: arbitration, 68000-style word/byte cycles, tenure limit
module zorro_dma_master
  import bluster_pkg::*;
#(
  parameter int BURST_MAX   = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        C7M,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [1:0]  ben,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic        BGn,
  input  logic        ASn_in,
  input  logic        DTACKn,
  input  logic        BEERn,
  input  logic        OWN_in,
  output logic        BRn,
  output logic        OWNn,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        READ,
  output logic [22:0] A,
  output logic [15:0] D_out,
  input  logic [15:0] D_in,
  output logic        bus_oe,
  output logic        d_oe
);

  logic s_bgn, s_asn, s_dtackn, s_beern, s_own;

  bluster_sync #(.STAGES(SYNC_STAGES)) u_sync_bg    (.clk(C7M), .rst(RESET), .d(BGn),    .q(s_bgn));
  bluster_sync #(.STAGES(SYNC_STAGES)) u_sync_as    (.clk(C7M), .rst(RESET), .d(ASn_in), .q(s_asn));
  bluster_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (.clk(C7M), .rst(RESET), .d(DTACKn), .q(s_dtackn));
  bluster_sync #(.STAGES(SYNC_STAGES)) u_sync_beer  (.clk(C7M), .rst(RESET), .d(BEERn),  .q(s_beern));
  bluster_sync #(.STAGES(SYNC_STAGES)) u_sync_own   (.clk(C7M), .rst(RESET), .d(OWN_in), .q(s_own));

  zdm_state_t state, nxt;
  logic [7:0] tcnt;
  logic [7:0] burst_cnt;
  logic [1:0] ben_q;
  logic       tmo, bus_free, more;

  assign tmo      = (tcnt == 8'(TIMEOUT - 1));
  assign bus_free = ~s_bgn & s_asn & s_dtackn & s_own;
  // Chaining needs a clean previous cycle, a waiting command, tenure budget and DTACK already negated
  assign more     = ~err & req & s_dtackn & ((int'(burst_cnt) + 1) < BURST_MAX);

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (req) nxt = REQ;
      REQ:      if (!s_bgn) nxt = WAITFREE;
      WAITFREE: begin
        if (s_bgn)         nxt = REQ;
        else if (bus_free) nxt = ADDR;
      end
      ADDR:     nxt = STRB;
      STRB:     nxt = WAIT;
      WAIT:     if (!s_beern || !s_dtackn || tmo) nxt = TERM;
      TERM:     nxt = more ? ADDR : REL;
      REL:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Every bus-visible output is a flop updated on state entry, so the pins never see a bus input combinationally
  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      BRn       <= NEGATED_L;
      OWNn      <= NEGATED_L;
      ASn       <= NEGATED_L;
      UDSn      <= NEGATED_L;
      LDSn      <= NEGATED_L;
      READ      <= 1'b1;
      bus_oe    <= 1'b0;
      d_oe      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      A         <= '0;
      D_out     <= '0;
      ben_q     <= 2'b11;
      tcnt      <= '0;
      burst_cnt <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;

      if (state == STRB)                     tcnt <= '0;
      else if (state == WAIT && tcnt != '1) tcnt <= tcnt + 8'd1;

      if (state == TERM)     burst_cnt <= burst_cnt + 8'd1;
      else if (state == REL) burst_cnt <= '0;

      if (nxt != state) begin
        case (nxt)
          REQ:  BRn <= ASSERTED_L;
          ADDR: begin
            A      <= addr;
            READ   <= ~we;
            D_out  <= wdata;
            d_oe   <= we;
            ben_q  <= fix_ben(ben);
            OWNn   <= ASSERTED_L;
            BRn    <= NEGATED_L;
            bus_oe <= 1'b1;
          end
          STRB: begin
            ASn <= ASSERTED_L;
            if (READ) begin
              UDSn <= ~ben_q[1];
              LDSn <= ~ben_q[0];
            end
          end
          // Write data strobes trail AS by one clock so D_out is settled on the backplane
          WAIT: if (!READ) begin
            UDSn <= ~ben_q[1];
            LDSn <= ~ben_q[0];
          end
          TERM: begin
            ASn  <= NEGATED_L;
            UDSn <= NEGATED_L;
            LDSn <= NEGATED_L;
            if (!s_beern) begin
              err <= 1'b1;
            end else if (!s_dtackn) begin
              ack <= 1'b1;
              if (READ) rdata <= D_in;
            end else begin
              err <= 1'b1;
            end
          end
          REL: begin
            OWNn   <= NEGATED_L;
            bus_oe <= 1'b0;
            d_oe   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zorro_dma_master.sv
// tb/tb_zorro_dma_master.sv - scoreboard bench with arbiter and bus-memory models for zorro_dma_master
module tb_zorro_dma_master;

  localparam int BURST_MAX = 4;
  localparam int TIMEOUT   = 64;

  logic        C7M = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [22:0] addr = '0;
  logic [1:0]  ben = 2'b11;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack, err;
  logic        BGn = 1'b1, ASn_in = 1'b1, DTACKn = 1'b1, BEERn = 1'b1, OWN_in = 1'b1;
  logic        BRn, OWNn, ASn, UDSn, LDSn, READ, bus_oe, d_oe;
  logic [22:0] A;
  logic [15:0] D_out;
  logic [15:0] D_in = '0;

  zorro_dma_master #(.BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .C7M(C7M), .RESET(RESET), .req(req), .we(we), .addr(addr), .ben(ben), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .BGn(BGn), .ASn_in(ASn_in), .DTACKn(DTACKn),
    .BEERn(BEERn), .OWN_in(OWN_in), .BRn(BRn), .OWNn(OWNn), .ASn(ASn), .UDSn(UDSn),
    .LDSn(LDSn), .READ(READ), .A(A), .D_out(D_out), .D_in(D_in), .bus_oe(bus_oe), .d_oe(d_oe)
  );

  initial forever #10 C7M = ~C7M;

  typedef struct {
    bit          is_err;
    bit          is_read;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mdl  [int];
  logic [15:0] bmem [int];
  int          ten_q[$];
  int          ten_cnt = 0;
  logic        prev_own = 1'b1;
  int          ncmp = 0, nfail = 0;

  logic        cur_we = 1'b0;
  logic [22:0] cur_addr = '0;
  logic [1:0]  cur_bf = 2'b11;
  logic [15:0] cur_wdata = '0;
  int          cur_mode = 0;   // 0 DTACK, 1 BEERn with DTACKn, 2 silent
  int          cur_dly = 0;
  int          gdelay = 0;
  int          gcnt = 0;
  bit          arb_auto = 1'b1;
  logic        bg_man = 1'b1;
  logic [1:0]  sl_nb;
  logic [15:0] sl_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mdl_rd(input int a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction

  function automatic logic [15:0] bmem_rd(input int a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  // Present one command and record what the local side must see back
  task automatic issue(input logic w, input logic [22:0] a, input logic [1:0] b,
                       input logic [15:0] d, input int mode, input int dly);
    exp_t        e;
    logic [1:0]  bf;
    logic [15:0] v;
    bf = (b == 2'b00) ? 2'b11 : b;
    req = 1'b1; we = w; addr = a; ben = b; wdata = d;
    cur_we = w; cur_addr = a; cur_bf = bf; cur_wdata = d; cur_mode = mode; cur_dly = dly;
    e.is_err  = (mode != 0);
    e.is_read = !w;
    e.data    = mdl_rd(int'(a));
    if (w && mode == 0) begin
      v = e.data;
      if (bf[1]) v[15:8] = d[15:8];
      if (bf[0]) v[7:0]  = d[7:0];
      mdl[int'(a)] = v;
    end
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge C7M);
      n++;
    end while (!(ack || err) && n < 400);
    if (!(ack || err)) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: no ack or err within 400 clocks", name);
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge C7M);
  endtask

  // Arbiter: grants gdelay clocks after BRn, holds grant through the tenure
  initial forever begin
    @(negedge C7M);
    if (!arb_auto) BGn = bg_man;
    else if (BRn && OWNn) begin
      BGn = 1'b1;
      gcnt = 0;
    end else if (!BRn) begin
      if (gcnt >= gdelay) BGn = 1'b0;
      else gcnt++;
    end
  end

  // Bus slave memory: checks strobes, answers with a one-clock DTACKn (and BEERn) pulse
  initial forever begin
    @(negedge C7M);
    if (!RESET && !ASn) begin
      chk("bus_addr", 32'(A), 32'(cur_addr));
      chk("read_level", 32'(READ), 32'(!cur_we));
      sl_nb = ~cur_bf;
      if (cur_we) begin
        chk("wr_ds_after_as", 32'({UDSn, LDSn}), 3);
        @(negedge C7M);
        chk("wr_ds", 32'({UDSn, LDSn}), 32'(sl_nb));
        chk("wr_data", 32'(D_out), 32'(cur_wdata));
        chk("wr_d_oe", 32'(d_oe), 1);
      end else begin
        chk("rd_ds", 32'({UDSn, LDSn}), 32'(sl_nb));
        chk("rd_d_oe", 32'(d_oe), 0);
      end
      if (cur_mode != 2) begin
        repeat (cur_dly) @(negedge C7M);
        if (!cur_we) D_in = bmem_rd(int'(A));
        else if (cur_mode == 0) begin
          sl_v = bmem_rd(int'(A));
          if (!UDSn) sl_v[15:8] = D_out[15:8];
          if (!LDSn) sl_v[7:0]  = D_out[7:0];
          bmem[int'(A)] = sl_v;
        end
        DTACKn = 1'b0;
        if (cur_mode == 1) BEERn = 1'b0;
        @(negedge C7M);
        DTACKn = 1'b1;
        BEERn  = 1'b1;
      end
      while (!ASn && !RESET) @(negedge C7M);
    end
  end

  // Monitor: pops the scoreboard on every response and tracks tenure lengths
  initial forever begin
    @(negedge C7M);
    if (!RESET) begin
      chk("brn_own_exclusive", 32'(!BRn && !OWNn), 0);
      if (prev_own && !OWNn) ten_cnt = 0;
      if (ack || err) begin
        chk("resp_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("resp_kind", 32'({ack, err}), mon_e.is_err ? 1 : 2);
          if (ack && mon_e.is_read && !mon_e.is_err) chk("rdata", 32'(rdata), 32'(mon_e.data));
        end
        if (!OWNn) ten_cnt++;
      end
      if (!prev_own && OWNn) begin
        ten_q.push_back(ten_cnt);
        chk("tenure_le_max", 32'(ten_cnt <= BURST_MAX), 1);
      end
    end
    prev_own = OWNn;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge C7M);
    chk("rst_BRn", 32'(BRn), 1);
    chk("rst_OWNn", 32'(OWNn), 1);
    chk("rst_strobes", 32'({ASn, UDSn, LDSn}), 7);
    chk("rst_READ", 32'(READ), 1);
    chk("rst_oe", 32'({bus_oe, d_oe}), 0);
    chk("rst_ack_err", 32'({ack, err}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    RESET = 1'b0;
    repeat (2) @(negedge C7M);

    // Word read of a preloaded location
    mdl[int'(23'h100000)]  = 16'hBEEF;
    bmem[int'(23'h100000)] = 16'hBEEF;
    gdelay = 3;
    issue(1'b0, 23'h100000, 2'b11, 16'h0000, 0, 2);
    wait_done("read");
    req = 1'b0;
    @(negedge C7M);
    chk("own_released_after_ack", 32'(OWNn), 1);
    idle(3);

    // Lower-byte write, then read the word back
    issue(1'b1, 23'h000040, 2'b01, 16'h00A5, 0, 1);
    wait_done("byte_write");
    idle(3);
    issue(1'b0, 23'h000040, 2'b11, 16'h0000, 0, 0);
    wait_done("byte_readback");
    idle(3);

    // Bus busy while granted, then grant withdrawn, then clean grant
    arb_auto = 1'b0; bg_man = 1'b1; ASn_in = 1'b0;
    issue(1'b0, 23'h000123, 2'b11, 16'h0000, 0, 1);
    repeat (3) @(negedge C7M);
    bg_man = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge C7M);
      chk("busy_bus_no_own", 32'(OWNn), 1);
    end
    bg_man = 1'b1;
    repeat (4) @(negedge C7M);
    chk("withdrawn_brn_low", 32'(BRn), 0);
    chk("withdrawn_no_own", 32'(OWNn), 1);
    ASn_in = 1'b1; bg_man = 1'b0;
    wait_done("contention");
    arb_auto = 1'b1;
    idle(4);

    // No DTACK at all
    gdelay = 0;
    issue(1'b0, 23'h0002AA, 2'b10, 16'h0000, 2, 0);
    n = 0;
    while (ASn && n < 200) begin @(negedge C7M); n++; end
    n = 0;
    while (!err && n < 200) begin @(negedge C7M); n++; end
    chk("timeout_window", 32'(n >= TIMEOUT && n <= TIMEOUT + 2), 1);
    idle(4);

    // BEERn together with DTACKn
    issue(1'b1, 23'h000055, 2'b11, 16'h1234, 1, 1);
    wait_done("bus_error");
    idle(4);

    // Six chained commands split across two tenures
    gdelay = 1;
    ten_q.delete();
    for (int i = 0; i < 6; i++) begin
      issue(1'(i % 2), 23'h000300 + 23'(i), 2'b11, 16'h1000 + 16'(i), 0, 0);
      wait_done("burst");
    end
    idle(6);
    chk("burst_tenures", 32'(ten_q.size()), 2);
    if (ten_q.size() == 2) begin
      chk("burst_first_len", 32'(ten_q[0]), 4);
      chk("burst_second_len", 32'(ten_q[1]), 2);
    end

    // Reset in the middle of WAIT
    gdelay = 0;
    issue(1'b1, 23'h000077, 2'b11, 16'hCAFE, 2, 0);
    n = 0;
    while (ASn && n < 200) begin @(negedge C7M); n++; end
    repeat (3) @(negedge C7M);
    RESET = 1'b1;
    #1;
    chk("midrst_strobes", 32'({ASn, UDSn, LDSn}), 7);
    chk("midrst_oe", 32'({bus_oe, d_oe}), 0);
    chk("midrst_own_br", 32'({OWNn, BRn}), 3);
    chk("midrst_ack_err", 32'({ack, err}), 0);
    sb.delete();
    mdl.delete(int'(23'h000077));
    req = 1'b0;
    repeat (3) @(negedge C7M);
    RESET = 1'b0;
    idle(4);

    // Randomized mix of reads, writes, byte lanes, errors and gaps
    for (int i = 0; i < 40; i++) begin
      gdelay = int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), 23'h000100 + 23'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)));
      wait_done("random");
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
    end
    idle(10);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
